// File: rtl/pc_return_stack.sv
// Return-address stack for the RAT CPU; feeds the PC mux FROM_STACK input.
// Pushes on CALL/interrupt entry, pops on RET/RETIE, with sticky error flags.
module pc_return_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    PUSH,
    input  logic                    POP,
    input  logic [ADDR_W-1:0]       PUSH_DATA,
    input  logic                    CLR_ERR,
    output logic [ADDR_W-1:0]       FROM_STACK,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pc_return_stack: DEPTH must be a power of two in 2..256");
        end
    endgenerate

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [PTR_W-1:0]  top_idx;
    logic              empty;
    logic              full;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign top_idx = PTR_W'(count_q - CNT_W'(1));

    // Next-state: push/pop priority resolution and sticky flag update.
    always_comb begin
        count_d     = count_q;
        overflow_d  = CLR_ERR ? 1'b0 : overflow_q;
        underflow_d = CLR_ERR ? 1'b0 : underflow_q;
        wr_en       = 1'b0;
        wr_addr     = top_idx;

        unique case ({PUSH, POP})
            2'b10: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    wr_addr = PTR_W'(count_q);
                    count_d = count_q + CNT_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            2'b11: begin
                // Push+pop on an empty stack degenerates to a plain push.
                wr_en = 1'b1;
                if (empty) begin
                    wr_addr = '0;
                    count_d = CNT_W'(1);
                end else begin
                    wr_addr = top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; entries above COUNT are never observed.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= PUSH_DATA;
        end
    end

    always_comb begin
        FROM_STACK = empty ? '0 : mem_q[top_idx];
    end

    assign EMPTY     = empty;
    assign FULL      = full;
    assign COUNT     = count_q;
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

endmodule
